// File: rtl/axi_ctrl_pkg.sv
// Shared types and field layout for the AXI control backend scheduler.
// LS entry: {rd_wr, addr[14:0], wdata[31:0], wstrb[3:0]}; SS entry: {data, tstrb, tkeep, user, tlast}.
package axi_ctrl_pkg;

  typedef enum logic {
    TRANS_LS = 1'b0,
    TRANS_SS = 1'b1
  } trans_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LM_WR   = 3'd1,
    ST_LM_RD   = 3'd2,
    ST_SM_WAIT = 3'd3,
    ST_SM_BUSY = 3'd4,
    ST_RD_RET  = 3'd5
  } sched_state_e;

  localparam int LS_RDWR_BIT  = 51;
  localparam int LS_ADDR_MSB  = 50;
  localparam int LS_ADDR_LSB  = 36;
  localparam int LS_WDATA_MSB = 35;
  localparam int LS_WDATA_LSB = 4;
  localparam int LS_WSTRB_MSB = 3;
  localparam int LS_WSTRB_LSB = 0;

  localparam int SS_DATA_MSB  = 42;
  localparam int SS_DATA_LSB  = 11;
  localparam int SS_TSTRB_MSB = 10;
  localparam int SS_TSTRB_LSB = 7;
  localparam int SS_TKEEP_MSB = 6;
  localparam int SS_TKEEP_LSB = 3;
  localparam int SS_USER_MSB  = 2;
  localparam int SS_USER_LSB  = 1;
  localparam int SS_TLAST_BIT = 0;

  // Returned to the LS side when a read is aborted by the done timeout.
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/axi_rr_arb2.sv
// Two-way round-robin grant between the LS and SS FIFOs; hold_ss forces an SS
// burst continuation and masks LS entirely.
module axi_rr_arb2
  import axi_ctrl_pkg::*;
(
  input  logic   req_ls,
  input  logic   req_ss,
  input  trans_e last_trans,
  input  logic   hold_ss,
  output logic   gnt_ls,
  output logic   gnt_ss
);

  always_comb begin
    gnt_ls = 1'b0;
    gnt_ss = 1'b0;
    if (hold_ss) begin
      gnt_ss = req_ss;
    end else if (req_ls && req_ss) begin
      // Tie goes to whichever side was not served last.
      if (last_trans == TRANS_SS) gnt_ls = 1'b1;
      else                        gnt_ss = 1'b1;
    end else begin
      gnt_ls = req_ls;
      gnt_ss = req_ss;
    end
  end

endmodule

// File: rtl/axi_trans_scheduler.sv
// Pops LS requests and SS beats, sequences them onto the LM/SM backend masters,
// returns LS read data and aborts any transaction whose done never arrives.
module axi_trans_scheduler
  import axi_ctrl_pkg::*;
#(
  parameter int          FIFO_LS_WIDTH = 52,
  parameter int          FIFO_SS_WIDTH = 43,
  parameter logic [31:0] LM_BASE_ADDR  = 32'h0000_0000,
  parameter int          SS_BURST_MAX  = 8,
  parameter int          DONE_TIMEOUT  = 1024
) (
  input  logic                     axi_aclk,
  input  logic                     axi_areset,
  input  logic                     fifo_ls_rd_vld,
  output logic                     fifo_ls_rd_rdy,
  input  logic [FIFO_LS_WIDTH-1:0] fifo_ls_data_out,
  input  logic                     fifo_ss_rd_vld,
  output logic                     fifo_ss_rd_rdy,
  input  logic [FIFO_SS_WIDTH-1:0] fifo_ss_data_out,
  output logic                     bk_lm_wstart,
  output logic [31:0]              bk_lm_waddr,
  output logic [31:0]              bk_lm_wdata,
  output logic [3:0]               bk_lm_wstrb,
  input  logic                     bk_lm_wdone,
  output logic                     bk_lm_rstart,
  output logic [31:0]              bk_lm_raddr,
  input  logic [31:0]              bk_lm_rdata,
  input  logic                     bk_lm_rdone,
  output logic [31:0]              bk_ls_rdata,
  output logic                     bk_ls_rdone,
  output logic                     bk_sm_start,
  output logic [31:0]              bk_sm_data,
  output logic [3:0]               bk_sm_tstrb,
  output logic [3:0]               bk_sm_tkeep,
  output logic [1:0]               bk_sm_user,
  input  logic                     bk_sm_nordy,
  input  logic                     bk_sm_done,
  output logic                     sched_busy,
  output logic                     err_timeout
);

  localparam logic [7:0]  BURST_LIM = 8'(SS_BURST_MAX);
  localparam logic [15:0] TMO_LAST  = 16'(DONE_TIMEOUT - 1);

  sched_state_e state_q, state_d;
  trans_e       last_q, last_d;
  logic [7:0]   burst_q, burst_d, burst_inc;
  logic [15:0]  tmo_q, tmo_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  sm_data_q, sm_data_d;
  logic [3:0]   sm_tstrb_q, sm_tstrb_d;
  logic [3:0]   sm_tkeep_q, sm_tkeep_d;
  logic [1:0]   sm_user_q, sm_user_d;
  logic         tlast_q, tlast_d;
  logic [31:0]  ls_rdata_q, ls_rdata_d;
  logic         wstart_q, wstart_d;
  logic         rstart_q, rstart_d;
  logic         err_q, err_d;

  logic idle, cont_ok, tmo_hit, gnt_ls, gnt_ss;

  assign idle      = (state_q == ST_IDLE);
  assign burst_inc = (burst_q == 8'hFF) ? 8'hFF : burst_q + 8'd1;
  assign tmo_hit   = (tmo_q == TMO_LAST);
  // A non-last beat may chain straight into the next one, unless LS is
  // waiting and this SS run has already used its share.
  assign cont_ok   = (state_q == ST_SM_BUSY) && bk_sm_done && !tlast_q && fifo_ss_rd_vld &&
                     (!fifo_ls_rd_vld || (burst_inc < BURST_LIM));

  axi_rr_arb2 u_arb (
    .req_ls     (idle & fifo_ls_rd_vld),
    .req_ss     ((idle | cont_ok) & fifo_ss_rd_vld),
    .last_trans (last_q),
    .hold_ss    (cont_ok),
    .gnt_ls     (gnt_ls),
    .gnt_ss     (gnt_ss)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    burst_d    = burst_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    sm_data_d  = sm_data_q;
    sm_tstrb_d = sm_tstrb_q;
    sm_tkeep_d = sm_tkeep_q;
    sm_user_d  = sm_user_q;
    tlast_d    = tlast_q;
    ls_rdata_d = ls_rdata_q;
    wstart_d   = 1'b0;
    rstart_d   = 1'b0;
    err_d      = 1'b0;

    if (gnt_ls) begin
      addr_d  = {17'b0, fifo_ls_data_out[LS_ADDR_MSB:LS_ADDR_LSB]} | LM_BASE_ADDR;
      wdata_d = fifo_ls_data_out[LS_WDATA_MSB:LS_WDATA_LSB];
      wstrb_d = fifo_ls_data_out[LS_WSTRB_MSB:LS_WSTRB_LSB];
    end
    if (gnt_ss) begin
      sm_data_d  = fifo_ss_data_out[SS_DATA_MSB:SS_DATA_LSB];
      sm_tstrb_d = fifo_ss_data_out[SS_TSTRB_MSB:SS_TSTRB_LSB];
      sm_tkeep_d = fifo_ss_data_out[SS_TKEEP_MSB:SS_TKEEP_LSB];
      sm_user_d  = fifo_ss_data_out[SS_USER_MSB:SS_USER_LSB];
      tlast_d    = fifo_ss_data_out[SS_TLAST_BIT];
    end

    case (state_q)
      ST_IDLE: begin
        if (gnt_ls) begin
          if (fifo_ls_data_out[LS_RDWR_BIT]) begin
            state_d  = ST_LM_WR;
            wstart_d = 1'b1;
          end else begin
            state_d  = ST_LM_RD;
            rstart_d = 1'b1;
          end
        end else if (gnt_ss) begin
          state_d = ST_SM_WAIT;
        end
      end
      ST_LM_WR: begin
        if (bk_lm_wdone) begin
          state_d = ST_IDLE;
          last_d  = TRANS_LS;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_LM_RD: begin
        if (bk_lm_rdone) begin
          state_d    = ST_RD_RET;
          last_d     = TRANS_LS;
          ls_rdata_d = bk_lm_rdata;
        end else if (tmo_hit) begin
          state_d    = ST_RD_RET;
          err_d      = 1'b1;
          ls_rdata_d = TIMEOUT_RDATA;
        end
      end
      ST_SM_WAIT: begin
        if (!bk_sm_nordy) state_d = ST_SM_BUSY;
      end
      ST_SM_BUSY: begin
        if (bk_sm_done) begin
          burst_d = burst_inc;
          last_d  = TRANS_SS;
          if (cont_ok) begin
            state_d = ST_SM_WAIT;
          end else begin
            state_d = ST_IDLE;
            burst_d = 8'd0;
          end
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          burst_d = 8'd0;
        end
      end
      ST_RD_RET: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    // Counter only advances while waiting for a done and restarts on every state change.
    tmo_d = 16'd0;
    if ((state_d == state_q) &&
        (state_q == ST_LM_WR || state_q == ST_LM_RD || state_q == ST_SM_BUSY))
      tmo_d = tmo_q + 16'd1;
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q    <= ST_IDLE;
      last_q     <= TRANS_SS;
      burst_q    <= 8'd0;
      tmo_q      <= 16'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
      sm_data_q  <= 32'd0;
      sm_tstrb_q <= 4'd0;
      sm_tkeep_q <= 4'd0;
      sm_user_q  <= 2'd0;
      tlast_q    <= 1'b0;
      ls_rdata_q <= 32'd0;
      wstart_q   <= 1'b0;
      rstart_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      burst_q    <= burst_d;
      tmo_q      <= tmo_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      sm_data_q  <= sm_data_d;
      sm_tstrb_q <= sm_tstrb_d;
      sm_tkeep_q <= sm_tkeep_d;
      sm_user_q  <= sm_user_d;
      tlast_q    <= tlast_d;
      ls_rdata_q <= ls_rdata_d;
      wstart_q   <= wstart_d;
      rstart_q   <= rstart_d;
      err_q      <= err_d;
    end
  end

  // Pops are masked during reset so no entry leaves a FIFO while the scheduler is held.
  assign fifo_ls_rd_rdy = gnt_ls & ~axi_areset;
  assign fifo_ss_rd_rdy = gnt_ss & ~axi_areset;

  assign bk_lm_wstart = wstart_q;
  assign bk_lm_waddr  = addr_q;
  assign bk_lm_wdata  = wdata_q;
  assign bk_lm_wstrb  = wstrb_q;
  assign bk_lm_rstart = rstart_q;
  assign bk_lm_raddr  = addr_q;
  assign bk_ls_rdata  = ls_rdata_q;
  assign bk_ls_rdone  = (state_q == ST_RD_RET);
  assign bk_sm_start  = (state_q == ST_SM_WAIT) & ~bk_sm_nordy;
  assign bk_sm_data   = sm_data_q;
  assign bk_sm_tstrb  = sm_tstrb_q;
  assign bk_sm_tkeep  = sm_tkeep_q;
  assign bk_sm_user   = sm_user_q;
  assign sched_busy   = ~idle;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_axi_trans_scheduler.sv
// Scoreboard bench for axi_trans_scheduler: directed LS/SS traffic, expected
// backend events queued at issue time and matched by an independent monitor.
module tb_axi_trans_scheduler;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fifo_ls_rd_vld, fifo_ls_rd_rdy;
  logic [51:0] fifo_ls_data_out;
  logic        fifo_ss_rd_vld, fifo_ss_rd_rdy;
  logic [42:0] fifo_ss_data_out;
  logic        bk_lm_wstart, bk_lm_wdone, bk_lm_rstart, bk_lm_rdone;
  logic [31:0] bk_lm_waddr, bk_lm_wdata, bk_lm_raddr, bk_lm_rdata, bk_ls_rdata;
  logic [3:0]  bk_lm_wstrb;
  logic        bk_ls_rdone, bk_sm_start, bk_sm_nordy, bk_sm_done;
  logic [31:0] bk_sm_data;
  logic [3:0]  bk_sm_tstrb, bk_sm_tkeep;
  logic [1:0]  bk_sm_user;
  logic        sched_busy, err_timeout;
  logic        any_out;

  always #5 clk = ~clk;

  axi_trans_scheduler #(
    .FIFO_LS_WIDTH(52), .FIFO_SS_WIDTH(43), .LM_BASE_ADDR(BASE),
    .SS_BURST_MAX(4), .DONE_TIMEOUT(16)
  ) dut (
    .axi_aclk(clk), .axi_areset(rst),
    .fifo_ls_rd_vld(fifo_ls_rd_vld), .fifo_ls_rd_rdy(fifo_ls_rd_rdy), .fifo_ls_data_out(fifo_ls_data_out),
    .fifo_ss_rd_vld(fifo_ss_rd_vld), .fifo_ss_rd_rdy(fifo_ss_rd_rdy), .fifo_ss_data_out(fifo_ss_data_out),
    .bk_lm_wstart(bk_lm_wstart), .bk_lm_waddr(bk_lm_waddr), .bk_lm_wdata(bk_lm_wdata),
    .bk_lm_wstrb(bk_lm_wstrb), .bk_lm_wdone(bk_lm_wdone),
    .bk_lm_rstart(bk_lm_rstart), .bk_lm_raddr(bk_lm_raddr), .bk_lm_rdata(bk_lm_rdata),
    .bk_lm_rdone(bk_lm_rdone), .bk_ls_rdata(bk_ls_rdata), .bk_ls_rdone(bk_ls_rdone),
    .bk_sm_start(bk_sm_start), .bk_sm_data(bk_sm_data), .bk_sm_tstrb(bk_sm_tstrb),
    .bk_sm_tkeep(bk_sm_tkeep), .bk_sm_user(bk_sm_user), .bk_sm_nordy(bk_sm_nordy),
    .bk_sm_done(bk_sm_done), .sched_busy(sched_busy), .err_timeout(err_timeout)
  );

  assign any_out = |{fifo_ls_rd_rdy, fifo_ss_rd_rdy, bk_lm_wstart, bk_lm_waddr, bk_lm_wdata,
                     bk_lm_wstrb, bk_lm_rstart, bk_lm_raddr, bk_ls_rdata, bk_ls_rdone,
                     bk_sm_start, bk_sm_data, bk_sm_tstrb, bk_sm_tkeep, bk_sm_user,
                     sched_busy, err_timeout};

  typedef struct {
    int          kind;   // 0 wstart, 1 rstart, 2 sm start, 3 ls rdone, 4 timeout
    logic [31:0] a;
    logic [31:0] b;
    logic [9:0]  c;
  } ev_t;

  ev_t         exp_q[$];
  logic [51:0] ls_q[$];
  logic [42:0] ss_q[$];
  int          checks = 0;
  int          failures = 0;
  int          lm_lat = 3, rd_lat = 2, sm_lat = 1;
  bit          rd_hold = 0, sm_hold = 0;
  logic [31:0] rd_val = 32'd0;
  bit          take_ls, take_ss;

  function automatic logic [51:0] ls_wr(logic [14:0] a, logic [31:0] d, logic [3:0] s);
    return {1'b1, a, d, s};
  endfunction
  function automatic logic [51:0] ls_rd(logic [14:0] a);
    return {1'b0, a, 36'd0};
  endfunction
  function automatic logic [42:0] ss_beat(logic [31:0] d, logic tl);
    return {d, d[3:0], ~d[3:0], d[5:4], tl};
  endfunction

  task automatic push_ev(int k, logic [31:0] a, logic [31:0] b, logic [9:0] c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask
  task automatic exp_wr(logic [14:0] a, logic [31:0] d, logic [3:0] s);
    push_ev(0, BASE | {17'd0, a}, d, {6'd0, s});
  endtask
  task automatic exp_rd(logic [14:0] a);
    push_ev(1, BASE | {17'd0, a}, 32'd0, 10'd0);
  endtask
  task automatic exp_sm(logic [42:0] bt);
    push_ev(2, bt[42:11], 32'd0, bt[10:1]);
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon(int k, logic [31:0] a, logic [31:0] b, logic [9:0] c);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard unexpected event kind=%0d a=%h b=%h c=%h", k, a, b, c);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.b !== b || e.c !== c) begin
        failures++;
        $display("FAIL scoreboard actual kind=%0d a=%h b=%h c=%h required kind=%0d a=%h b=%h c=%h",
                 k, a, b, c, e.kind, e.a, e.b, e.c);
      end
    end
  endtask

  // which: 0 LS pop, 1 SS pop, 2 lm rdone, 3 lm rstart, 4 sm start
  task automatic wait_for(string name, int which);
    bit hit = 0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      case (which)
        0: hit = fifo_ls_rd_rdy && fifo_ls_rd_vld;
        1: hit = fifo_ss_rd_rdy && fifo_ss_rd_vld;
        2: hit = bk_lm_rdone;
        3: hit = bk_lm_rstart;
        default: hit = bk_sm_start;
      endcase
    end
    check(name, hit, 1);
  endtask

  task automatic wait_quiet(string name);
    bit q = 0;
    for (int k = 0; k < 400 && !q; k++) begin
      @(negedge clk);
      q = !sched_busy && ls_q.size() == 0 && ss_q.size() == 0 && exp_q.size() == 0;
    end
    check(name, q, 1);
  endtask

  // FIFO models: pop decided from pre-edge handshake, head updated just after the edge.
  initial begin
    fifo_ls_rd_vld = 0; fifo_ls_data_out = '0;
    fifo_ss_rd_vld = 0; fifo_ss_data_out = '0;
    forever begin
      @(negedge clk);
      take_ls = fifo_ls_rd_rdy && fifo_ls_rd_vld;
      take_ss = fifo_ss_rd_rdy && fifo_ss_rd_vld;
      @(posedge clk);
      #1;
      if (take_ls) void'(ls_q.pop_front());
      if (take_ss) void'(ss_q.pop_front());
      fifo_ls_rd_vld   = ls_q.size() > 0;
      fifo_ls_data_out = (ls_q.size() > 0) ? ls_q[0] : '0;
      fifo_ss_rd_vld   = ss_q.size() > 0;
      fifo_ss_data_out = (ss_q.size() > 0) ? ss_q[0] : '0;
    end
  end

  // Backend responders.
  initial begin
    bk_lm_wdone = 0;
    forever begin
      @(negedge clk);
      if (bk_lm_wstart && !rst) begin
        repeat (lm_lat) @(posedge clk);
        #1 bk_lm_wdone = 1;
        @(posedge clk);
        #1 bk_lm_wdone = 0;
      end
    end
  end
  initial begin
    bk_lm_rdone = 0; bk_lm_rdata = '0;
    forever begin
      @(negedge clk);
      if (bk_lm_rstart && !rst && !rd_hold) begin
        repeat (rd_lat) @(posedge clk);
        #1 bk_lm_rdone = 1; bk_lm_rdata = rd_val;
        @(posedge clk);
        #1 bk_lm_rdone = 0; bk_lm_rdata = '0;
      end
    end
  end
  initial begin
    bk_sm_done = 0;
    forever begin
      @(negedge clk);
      if (bk_sm_start && !rst && !sm_hold) begin
        repeat (sm_lat) @(posedge clk);
        #1 bk_sm_done = 1;
        @(posedge clk);
        #1 bk_sm_done = 0;
      end
    end
  end

  // Monitor: every presented backend/return event is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bk_lm_wstart) mon(0, bk_lm_waddr, bk_lm_wdata, {6'd0, bk_lm_wstrb});
        if (bk_lm_rstart) mon(1, bk_lm_raddr, 32'd0, 10'd0);
        if (bk_sm_start)  mon(2, bk_sm_data, 32'd0, {bk_sm_tstrb, bk_sm_tkeep, bk_sm_user});
        if (err_timeout)  mon(4, 32'd0, 32'd0, 10'd0);
        if (bk_ls_rdone)  mon(3, bk_ls_rdata, 32'd0, 10'd0);
      end
    end
  end

  initial begin
    logic [42:0] bt, bt2;
    int k;
    rst = 1; bk_sm_nordy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", any_out, 0);
    @(posedge clk); #1 rst = 0;

    // LS write: pop at t, wstart at t+1, wdone at t+4, idle at t+5.
    ls_q.push_back(ls_wr(15'h0010, 32'hA5A5_0001, 4'hF));
    exp_wr(15'h0010, 32'hA5A5_0001, 4'hF);
    wait_for("wr_pop", 0);
    @(negedge clk);
    check("wr_start_t1", bk_lm_wstart, 1);
    check("wr_addr", bk_lm_waddr, 32'h3000_0010);
    @(negedge clk);
    check("wr_start_pulse", bk_lm_wstart, 0);
    check("wr_data_hold", {bk_lm_waddr, bk_lm_wdata}, {32'h3000_0010, 32'hA5A5_0001});
    @(negedge clk);
    @(negedge clk);
    check("wr_busy_t4", sched_busy, 1);
    @(negedge clk);
    check("wr_idle_t5", sched_busy, 0);
    wait_quiet("wr_quiet");

    // LS read with data returned one cycle after rdone.
    rd_val = 32'h1234_5678;
    ls_q.push_back(ls_rd(15'h0020));
    exp_rd(15'h0020);
    push_ev(3, 32'h1234_5678, 32'd0, 10'd0);
    wait_for("rd_rdone_seen", 2);
    @(negedge clk);
    check("rd_return", {bk_ls_rdone, bk_ls_rdata}, {1'b1, 32'h1234_5678});
    @(negedge clk);
    check("rd_return_pulse_hold", {bk_ls_rdone, bk_ls_rdata}, {1'b0, 32'h1234_5678});
    wait_quiet("rd_quiet");

    // SS beat held off by nordy for 10 cycles.
    bk_sm_nordy = 1;
    bt = ss_beat(32'hC0DE_0003, 1'b1);
    ss_q.push_back(bt);
    exp_sm(bt);
    wait_for("nordy_pop", 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("nordy_no_start", {bk_sm_start, bk_sm_data}, {1'b0, 32'hC0DE_0003});
    end
    @(posedge clk); #1 bk_sm_nordy = 0;
    @(negedge clk);
    check("nordy_release_start", {bk_sm_start, bk_sm_data}, {1'b1, 32'hC0DE_0003});
    wait_quiet("nordy_quiet");

    // Both FIFOs loaded, burst limit 4: LS, SS x4, LS, SS x4.
    ls_q.push_back(ls_wr(15'h0100, 32'h1111_0001, 4'h3));
    ls_q.push_back(ls_wr(15'h0104, 32'h1111_0002, 4'hC));
    for (int i = 1; i <= 8; i++) ss_q.push_back(ss_beat(32'h5500_0000 + i, 1'b0));
    exp_wr(15'h0100, 32'h1111_0001, 4'h3);
    for (int i = 1; i <= 4; i++) exp_sm(ss_beat(32'h5500_0000 + i, 1'b0));
    exp_wr(15'h0104, 32'h1111_0002, 4'hC);
    for (int i = 5; i <= 8; i++) exp_sm(ss_beat(32'h5500_0000 + i, 1'b0));
    wait_quiet("burst_quiet");

    // Withheld rdone: abort 16 cycles after entering LM_RD, sentinel returned.
    rd_hold = 1;
    ls_q.push_back(ls_rd(15'h0030));
    exp_rd(15'h0030);
    push_ev(4, 32'd0, 32'd0, 10'd0);
    push_ev(3, 32'hDEAD_BEEF, 32'd0, 10'd0);
    wait_for("tmo_rstart", 3);
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (err_timeout) k = i;
    end
    check("tmo_latency", k, 16);
    check("tmo_sentinel", {bk_ls_rdone, bk_ls_rdata}, {1'b1, 32'hDEAD_BEEF});
    wait_quiet("tmo_quiet");
    rd_hold = 0;
    ls_q.push_back(ls_wr(15'h0040, 32'hBEEF_0005, 4'h1));
    exp_wr(15'h0040, 32'hBEEF_0005, 4'h1);
    wait_quiet("after_tmo_quiet");

    // Reset in SM_BUSY: outputs drop immediately, in-flight beat lost.
    sm_hold = 1;
    bt = ss_beat(32'h7777_0006, 1'b0);
    ss_q.push_back(bt);
    exp_sm(bt);
    wait_for("rst_sm_start", 4);
    @(posedge clk); #2 rst = 1;
    #1 check("rst_async_outputs", any_out, 0);
    bt2 = ss_beat(32'h8888_0007, 1'b1);
    ss_q.push_back(bt2);
    exp_sm(bt2);
    sm_hold = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_quiet("rst_ss_only_quiet");

    // Reset with both FIFOs waiting: LS wins the first tie.
    @(posedge clk); #1 rst = 1;
    ls_q.push_back(ls_wr(15'h0050, 32'h0000_0008, 4'hF));
    bt = ss_beat(32'h9999_0009, 1'b1);
    ss_q.push_back(bt);
    exp_wr(15'h0050, 32'h0000_0008, 4'hF);
    exp_sm(bt);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    wait_quiet("rst_tie_quiet");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_trans_scheduler.md
Name: axi_trans_scheduler

Overview:
- Sequences queued backend transactions onto the shared backend masters in the AXI control logic.
- Pops the LS request FIFO (AXI-Lite write/read requests) and the SS stream FIFO (AXI-Stream beats) under round-robin arbitration with an SS burst limit.
- Drives the LM (AXI-Lite master) and SM (AXI-Stream master) backend handshakes and returns LS read data.
- Sits between the two FIFOs and the backend master interfaces.

Parameters:
- FIFO_LS_WIDTH, 52, LS entry width: {rd_wr 1 (1=write), addr 15, wdata 32, wstrb 4}; reads carry 36 zero LSBs.
- FIFO_SS_WIDTH, 43, SS entry width: {data 32, tstrb 4, tkeep 4, user 2, tlast 1}.
- LM_BASE_ADDR, 32'h0000_0000, OR'ed onto the zero-extended 15-bit LS address to form the LM address.
- SS_BURST_MAX, 8, maximum consecutive SS beats while LS is pending (range 1..255).
- DONE_TIMEOUT, 1024, cycles to wait for any done before aborting (range 1..65535).

Ports:
- axi_aclk  in  1  clock.
- axi_areset  in  1  asynchronous, active-high reset.
- fifo_ls_rd_vld  in  1  LS FIFO has an entry.
- fifo_ls_rd_rdy  out  1  pop LS FIFO; entry transfers when rdy&vld.
- fifo_ls_data_out  in  FIFO_LS_WIDTH  LS head entry.
- fifo_ss_rd_vld  in  1  SS FIFO has an entry.
- fifo_ss_rd_rdy  out  1  pop SS FIFO.
- fifo_ss_data_out  in  FIFO_SS_WIDTH  SS head entry.
- bk_lm_wstart  out  1  LM write start pulse.
- bk_lm_waddr  out  32  LM write address.
- bk_lm_wdata  out  32  LM write data.
- bk_lm_wstrb  out  4  LM write strobes.
- bk_lm_wdone  in  1  LM write done pulse.
- bk_lm_rstart  out  1  LM read start pulse.
- bk_lm_raddr  out  32  LM read address.
- bk_lm_rdata  in  32  LM read data, valid with rdone.
- bk_lm_rdone  in  1  LM read done pulse.
- bk_ls_rdata  out  32  read data returned to the LS side.
- bk_ls_rdone  out  1  read-return pulse.
- bk_sm_start  out  1  SM beat start pulse.
- bk_sm_data  out  32  SM beat data.
- bk_sm_tstrb  out  4  SM beat tstrb.
- bk_sm_tkeep  out  4  SM beat tkeep.
- bk_sm_user  out  2  SM beat user.
- bk_sm_nordy  in  1  SM cannot accept a start.
- bk_sm_done  in  1  SM beat done pulse.
- sched_busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset: all outputs 0; state IDLE; last_trans=TRANS_SS, so LS wins the first tie; burst_cnt=0; timeout counter=0.
- States: IDLE, LM_WR, LM_RD, SM_WAIT, SM_BUSY, RD_RET.
- IDLE grant rule:
  - Only LS valid: grant LS. Only SS valid: grant SS.
  - Both valid: grant the one not equal to last_trans.
  - The matching rd_rdy is asserted combinationally in the same cycle; the entry is captured into registers at that edge.
  - No other state asserts rd_rdy, except the SS burst continuation below.
- LS grant:
  - rd_wr=1 goes to LM_WR; rd_wr=0 goes to LM_RD.
  - The start pulse is exactly one cycle, on the first cycle in the state (grant at cycle t, start at t+1).
  - addr/data/strb are held stable from the start pulse until done.
- LM_WR: on bk_lm_wdone go to IDLE; last_trans=LS.
- LM_RD: on bk_lm_rdone register bk_lm_rdata into bk_ls_rdata and go to RD_RET. RD_RET pulses bk_ls_rdone for one cycle, then goes to IDLE. bk_ls_rdata holds its value until the next read return.
- SS grant: go to SM_WAIT.
  - SM_WAIT: while bk_sm_nordy=1, stay and keep start=0. The first cycle with nordy=0 pulses bk_sm_start, then go to SM_BUSY.
  - sm data/tstrb/tkeep/user are held stable through SM_BUSY.
- SM_BUSY on bk_sm_done: burst_cnt+1 (saturating at 255); last_trans=SS. Then:
  - If tlast=0, SS valid, and (LS not valid or burst_cnt+1 < SS_BURST_MAX): pop SS in that done cycle and go to SM_WAIT (burst continuation).
  - Otherwise go to IDLE and clear burst_cnt.
- A tlast beat always ends the burst.
- Done inputs are ignored outside their waiting state. Done never coincides with start; the earliest legal done is the cycle after start.
- Timeout:
  - The counter runs in LM_WR, LM_RD and SM_BUSY and clears on state entry.
  - Reaching DONE_TIMEOUT pulses err_timeout and returns to IDLE.
  - The entry is dropped. An aborted LS read still performs RD_RET with bk_ls_rdata=32'hDEAD_BEEF.
- Reset asserted mid-operation: the in-flight entry is lost; no re-push; outputs return to 0 asynchronously.
- Address formation: {17'b0, addr15} | LM_BASE_ADDR.

Decomposition:
- Package axi_ctrl_pkg holds:
  - trans_e {TRANS_LS, TRANS_SS};
  - sched_state_e;
  - LS/SS field bit-position localparams;
  - the timeout read sentinel.
- One sub-module: axi_rr_arb2, the 2-way round-robin grant using last_trans plus burst-hold input, combinational.

Test Plan:
- LS write {1, 15'h0010, 32'hA5A5_0001, 4'hF}, LM_BASE_ADDR=32'h3000_0000 -> pop at t; wstart at t+1 with waddr=32'h3000_0010; wdone at t+4 -> sched_busy low at t+5.
- LS read addr 15'h0020, rdone with rdata=32'h1234_5678 -> bk_ls_rdone pulse one cycle later with bk_ls_rdata=32'h1234_5678.
- Both FIFOs always valid, SS beats with tlast=0, SS_BURST_MAX=4 -> grant order LS, SS×4, LS, SS×4; no SS run longer than 4.
- SS beat with bk_sm_nordy held high for 10 cycles -> no bk_sm_start until the first nordy=0 cycle; payload stable throughout.
- Withhold bk_lm_rdone, DONE_TIMEOUT=16 -> err_timeout pulse 16 cycles after entering LM_RD; bk_ls_rdone with 32'hDEAD_BEEF; next request is served normally.
- Assert axi_areset during SM_BUSY -> all outputs 0 immediately; after release, the next SS entry is granted first only if LS is empty.
